// File: rtl/boothr4_pkg.sv
`default_nettype none
// ============================================================================
// Package     : boothr4_pkg
// Description : Shared state encodings and default sizing for the Booth
//               radix-4 multiplier scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package boothr4_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        START = 3'd2,
        LOAD  = 3'd3,
        WAIT  = 3'd4,
        RUN   = 3'd5,
        RESP  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/boothr4_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface   : boothr4_scheduler_if
// Description : Requester, response and multiplier-side signals of the
//               scheduler. slave = scheduler, master = surrounding system.
// Revision    : 1.0 - initial release
// ============================================================================
interface boothr4_scheduler_if
    import boothr4_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [2*WIDTH-1:0]    rsp_product;
    logic                  rsp_err;
    logic                  mul_begin;
    logic                  mul_lock;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic                  mul_busy;
    logic [2*WIDTH-1:0]    mul_product;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_busy, mul_product,
        output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err,
               mul_begin, mul_lock, mul_a, mul_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_busy, mul_product,
        input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err,
               mul_begin, mul_lock, mul_a, mul_b
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; search begins at ptr and
//               wraps modulo NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import boothr4_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = $clog2(NREQ)
) (
    input  wire logic [NREQ-1:0] req,
    input  wire logic [IW-1:0]   ptr,
    output logic      [NREQ-1:0] grant,
    output logic      [IW-1:0]   idx,
    output logic                 any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!any && req[k] && (((int'(ptr) + i) % NREQ) == k)) begin
                    grant[k] = 1'b1;
                    idx      = IW'(k);
                    any      = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/boothr4_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : boothr4_scheduler
// Description : Round-robin scheduler sharing one radix-4 Booth multiplier
//               among NREQ requesters, with timeout-protected response path.
// Revision    : 1.0 - initial release
// ============================================================================
module boothr4_scheduler
    import boothr4_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input wire logic           clk,
    input wire logic           rst,
    boothr4_scheduler_if.slave bus
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t              r_state;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_idx;
    logic [CW-1:0]       r_cnt;
    logic [NREQ-1:0]     r_req_ready;
    logic                r_mul_begin;
    logic                r_mul_lock;
    logic [WIDTH-1:0]    r_mul_a;
    logic [WIDTH-1:0]    r_mul_b;
    logic                r_rsp_valid;
    logic [IW-1:0]       r_rsp_id;
    logic [2*WIDTH-1:0]  r_rsp_product;
    logic                r_rsp_err;

    logic [NREQ-1:0]     w_grant;
    logic [IW-1:0]       w_idx;
    logic                w_any;
    logic [WIDTH-1:0]    w_sel_a;
    logic [WIDTH-1:0]    w_sel_b;
    logic                w_expired;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_idx == IW'(i)) begin
                w_sel_a = bus.req_a[i*WIDTH +: WIDTH];
                w_sel_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Counter saturates at TIMEOUT, so it cannot wrap across WAIT and RUN.
    assign w_expired = (r_cnt >= CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_req_ready   <= '0;
            r_mul_begin   <= 1'b0;
            r_mul_lock    <= 1'b0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            r_req_ready <= '0;
            r_mul_begin <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Winner chosen here so req_ready is a registered pulse in GRANT.
                    if (w_any) begin
                        r_req_ready <= w_grant;
                        r_idx       <= w_idx;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    r_mul_a     <= w_sel_a;
                    r_mul_b     <= w_sel_b;
                    r_rsp_id    <= r_idx;
                    r_ptr       <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);
                    r_mul_begin <= 1'b1;
                    r_state     <= START;
                end
                START: begin
                    r_mul_lock <= 1'b1;
                    r_state    <= LOAD;
                end
                LOAD: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (bus.mul_busy) begin
                        r_mul_lock <= 1'b0;
                        r_cnt      <= r_cnt + CW'(1);
                        r_state    <= RUN;
                    end else if (w_expired) begin
                        r_mul_lock    <= 1'b0;
                        r_rsp_product <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (!bus.mul_busy) begin
                        r_rsp_product <= bus.mul_product;
                        r_rsp_err     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else if (w_expired) begin
                        r_rsp_product <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.mul_begin   = r_mul_begin;
    assign bus.mul_lock    = r_mul_lock;
    assign bus.mul_a       = r_mul_a;
    assign bus.mul_b       = r_mul_b;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_product = r_rsp_product;
    assign bus.rsp_err     = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_boothr4_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_boothr4_scheduler
// Description : Directed self-checking bench for boothr4_scheduler with a
//               behavioural multi-cycle multiplier on the datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boothr4_scheduler;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    bit   mul_en;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    boothr4_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    boothr4_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Multiplier stand-in: busy for a few cycles after the lock strobe.
    initial begin
        logic signed [WIDTH-1:0] a_l, b_l;
        int cnt;
        a_l = '0; b_l = '0; cnt = 0;
        bus.mul_busy    = 1'b0;
        bus.mul_product = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                bus.mul_busy = 1'b0;
                cnt = 0;
            end else if (bus.mul_busy) begin
                if (cnt == 0) begin
                    bus.mul_busy    = 1'b0;
                    bus.mul_product = a_l * b_l;
                end else begin
                    cnt--;
                end
            end else if (mul_en && bus.mul_lock) begin
                a_l = bus.mul_a;
                b_l = bus.mul_b;
                bus.mul_busy = 1'b1;
                cnt = 3;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[id*WIDTH +: WIDTH] = a;
        bus.req_b[id*WIDTH +: WIDTH] = b;
        bus.req_valid[id] = 1'b1;
    endtask

    task automatic run_one(input int exp_id, input logic [15:0] exp_prod, input bit exp_err,
                           input int hold, input int exp_tlat,
                           input logic [7:0] exp_a, input logic [7:0] exp_b, output int glat);
        int n;
        logic [15:0] held;
        bus.rsp_ready = (hold == 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_ready == '0 && n < 50);
        glat = n;
        check("req_ready", 32'(bus.req_ready), 32'(1) << exp_id);
        bus.req_valid[exp_id] = 1'b0;
        @(negedge clk);
        check("mul_begin", 32'(bus.mul_begin), 32'd1);
        check("mul_ab", 32'({bus.mul_a, bus.mul_b}), 32'({exp_a, exp_b}));
        n = 0;
        while (!bus.rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_tlat >= 0) check("rsp_latency", 32'(n), 32'(exp_tlat));
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_product", 32'(bus.rsp_product), 32'(exp_prod));
        check("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        held = bus.rsp_product;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("stall", 32'({bus.rsp_valid, bus.req_ready, bus.rsp_product}),
                  32'({1'b1, 4'b0000, held}));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        logic [15:0] rr_prod[4];
        int glat;
        int n;
        int id;

        vecs[0] = '{id: 0, a: 8'd7,    b: 8'hFD, prod: 16'hFFEB};
        vecs[1] = '{id: 2, a: 8'h80,   b: 8'h80, prod: 16'h4000};
        vecs[2] = '{id: 3, a: 8'd127,  b: 8'h80, prod: 16'hC080};
        vecs[3] = '{id: 1, a: 8'hFF,   b: 8'hFF, prod: 16'h0001};
        vecs[4] = '{id: 1, a: 8'd0,    b: 8'hB3, prod: 16'h0000};
        vecs[5] = '{id: 0, a: 8'd127,  b: 8'd127, prod: 16'h3F01};
        rr_prod[0] = 16'hFFFE;
        rr_prod[1] = 16'hFFFA;
        rr_prod[2] = 16'hFFF4;
        rr_prod[3] = 16'hFFEC;

        rst = 1'b1;
        mul_en = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check("reset_ctrl", 32'({bus.mul_begin, bus.mul_lock, bus.rsp_valid, bus.rsp_err}), 32'd0);
        check("reset_operands", 32'({bus.mul_a, bus.mul_b}), 32'd0);
        check("reset_rsp", 32'({bus.rsp_id, bus.rsp_product}), 32'd0);
        rst = 1'b0;

        // Round-robin from reset: all four valid, expect 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'(-(i + 2)));
        for (int k = 0; k < 5; k++) begin
            id = k % NREQ;
            run_one(id, rr_prod[id], 1'b0, (k == 2) ? 10 : 0, -1,
                    8'(id + 1), 8'(-(id + 2)), glat);
            check("rr_grant_latency", 32'(glat), 32'd1);
            if (k < 4) bus.req_valid[id] = 1'b1;
        end
        bus.req_valid = '0;

        for (int v = 0; v < 6; v++) begin
            set_req(vecs[v].id, vecs[v].a, vecs[v].b);
            run_one(vecs[v].id, vecs[v].prod, 1'b0, 0, -1, vecs[v].a, vecs[v].b, glat);
            check("vec_grant_latency", 32'(glat), 32'd1);
        end

        // Multiplier never responds: timeout after TIMEOUT cycles in WAIT.
        mul_en = 1'b0;
        set_req(1, 8'd5, 8'd5);
        run_one(1, 16'h0000, 1'b1, 0, TIMEOUT + 2, 8'd5, 8'd5, glat);
        mul_en = 1'b1;
        set_req(1, 8'd7, 8'hFD);
        run_one(1, 16'hFFEB, 1'b0, 0, -1, 8'd7, 8'hFD, glat);
        check("post_timeout_latency", 32'(glat), 32'd1);

        // Reset while the multiplier is running.
        set_req(0, 8'd3, 8'd4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_ready == '0 && n < 50);
        check("mid_grant", 32'(bus.req_ready), 32'd1);
        set_req(2, 8'd2, 8'd2);
        n = 0;
        while (!(bus.mul_busy && !bus.mul_lock) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reached_run", 32'({bus.mul_busy, bus.mul_lock}), 32'b10);
        #1 rst = 1'b1;
        #1;
        check("async_req_ready", 32'(bus.req_ready), 32'd0);
        check("async_ctrl", 32'({bus.mul_begin, bus.mul_lock, bus.rsp_valid, bus.rsp_err}), 32'd0);
        check("async_operands", 32'({bus.mul_a, bus.mul_b}), 32'd0);
        check("async_rsp", 32'({bus.rsp_id, bus.rsp_product}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_one(0, 16'h000C, 1'b0, 0, -1, 8'd3, 8'd4, glat);
        check("after_reset_latency", 32'(glat), 32'd1);
        run_one(2, 16'h0004, 1'b0, 0, -1, 8'd2, 8'd2, glat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
